// File: rtl/tinyalu_pkg.sv
// ============================================================================
// Module   : tinyalu_pkg
// Brief    : Opcode and FSM state types shared by the tinyalu_stream block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tinyalu_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_MUL  = 3'b100,
        OP_SUB  = 3'b101,
        OP_ILL6 = 3'b110,
        OP_ILL7 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_legal(op_e op);
        return !((op == OP_ILL6) || (op == OP_ILL7));
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mult_pipe.sv
// ============================================================================
// Module   : alu_mult_pipe
// Brief    : Registered unsigned multiplier, MUL_LATENCY-1 internal stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mult_pipe
    import tinyalu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product
);

    // The consumer's result register is the last of the MUL_LATENCY stages,
    // so only MUL_LATENCY-1 live here (requires MUL_LATENCY >= 2).
    localparam int STAGES = MUL_LATENCY - 1;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] r_stage [STAGES];

    assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            if (en) begin
                r_stage[0] <= w_prod;
            end
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign product = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/tinyalu_stream.sv
// ============================================================================
// Module   : tinyalu_stream
// Brief    : Flow-controlled WIDTH-bit ALU with pipelined multiply path.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tinyalu_stream
    import tinyalu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
);

    localparam int                CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam bit                HAS_EXEC = (MUL_LATENCY > 1);

    state_e              r_state;
    state_e              w_next;
    logic [CNT_W-1:0]    r_cnt;
    op_e                 w_op;
    logic                w_accept;
    logic                w_is_mul;
    logic                w_mul_en;
    logic                w_load;
    logic [2*WIDTH-1:0]  w_mul_product;
    logic [2*WIDTH-1:0]  w_alu_res;
    logic                w_alu_err;

    assign w_op     = op_e'(op);
    assign w_is_mul = (w_op == OP_MUL);
    assign w_accept = in_valid && in_ready;
    assign w_mul_en = w_accept && w_is_mul;

    generate
        if (MUL_LATENCY > 1) begin : g_mul_pipe
            alu_mult_pipe #(
                .WIDTH       (WIDTH),
                .MUL_LATENCY (MUL_LATENCY)
            ) u_mult (
                .clk     (clk),
                .rst     (rst),
                .en      (w_mul_en),
                .a       (a),
                .b       (b),
                .product (w_mul_product)
            );
        end else begin : g_mul_comb
            // Single-cycle multiply: product is taken straight into the result register.
            assign w_mul_product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        end
    endgenerate

    // Single-cycle ops are evaluated on the operands present at acceptance.
    always_comb begin
        w_alu_res = '0;
        w_alu_err = !is_legal(w_op);
        case (w_op)
            OP_NOP:  w_alu_res = '0;
            OP_ADD:  w_alu_res = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
            OP_AND:  w_alu_res = {{WIDTH{1'b0}}, a & b};
            OP_XOR:  w_alu_res = {{WIDTH{1'b0}}, a ^ b};
            OP_MUL:  w_alu_res = w_mul_product;
            OP_SUB:  w_alu_res = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_is_mul && HAS_EXEC) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (r_cnt == CNT_ONE) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_next = (w_is_mul && HAS_EXEC) ? EXEC : DONE;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_next == EXEC) && (r_state != EXEC)) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == EXEC) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // Result/err update only on the edge that enters (or re-enters) DONE.
    assign w_load = (w_next == DONE) && ((r_state != DONE) || w_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            err    <= 1'b0;
        end else if (w_load) begin
            if (r_state == EXEC) begin
                result <= w_mul_product;
                err    <= 1'b0;
            end else begin
                result <= w_alu_res;
                err    <= w_alu_err;
            end
        end else if (w_next != DONE) begin
            err <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tinyalu_stream.sv
// ============================================================================
// Module   : tb_tinyalu_stream
// Brief    : Directed + random bench for tinyalu_stream against a transaction model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tinyalu_stream;

    localparam int WIDTH       = 8;
    localparam int MUL_LATENCY = 3;
    localparam int RW          = 2 * WIDTH;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [2:0]        op        = 3'd0;
    logic [WIDTH-1:0]  a         = '0;
    logic [WIDTH-1:0]  b         = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [RW-1:0]     result;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the single outstanding transaction
    bit            pend       = 1'b0;
    logic [RW-1:0] pend_res   = '0;
    bit            pend_err   = 1'b0;
    int            pend_ready = 0;
    logic [RW-1:0] last_res   = '0;
    int            cyc        = 0;

    tinyalu_stream #(
        .WIDTH       (WIDTH),
        .MUL_LATENCY (MUL_LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] ref_result(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        longint unsigned ux;
        longint unsigned uy;
        ux = 64'(x);
        uy = 64'(y);
        case (o)
            3'd1:    return RW'(ux + uy);
            3'd2:    return RW'(ux & uy);
            3'd3:    return RW'(ux ^ uy);
            3'd4:    return RW'(ux * uy);
            3'd5:    return RW'(ux - uy);
            default: return '0;
        endcase
    endfunction

    // One clock period: drive at negedge, check outputs, then advance the model
    // past the coming posedge.
    task automatic step(input bit r, input bit iv, input logic [2:0] o,
                        input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit ordy);
        bit exp_valid;
        bit exp_ready;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        op        = o;
        a         = x;
        b         = y;
        out_ready = ordy;
        #1;
        exp_valid = pend && (cyc >= pend_ready);
        check_val("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check_val("result", result, pend_res);
            check_val("err", err, pend_err);
            last_res = pend_res;
        end else begin
            check_val("result_hold", result, last_res);
            check_val("err_idle", err, 1'b0);
        end
        exp_ready = !r && (!pend || (exp_valid && ordy));
        check_val("in_ready", in_ready, exp_ready);
        if (r) begin
            pend     = 1'b0;
            last_res = '0;
        end else begin
            if (exp_valid && ordy) pend = 1'b0;
            if (iv && exp_ready) begin
                pend       = 1'b1;
                pend_res   = ref_result(o, x, y);
                pend_err   = (o >= 3'd6);
                pend_ready = cyc + ((o == 3'd4) ? MUL_LATENCY : 1);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, '0, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1);
        idle(1);

        // ADD with carry into bit WIDTH
        step(1'b0, 1'b1, 3'd1, 8'hFF, 8'h01, 1'b1);
        idle(2);

        // MUL full-scale
        step(1'b0, 1'b1, 3'd4, 8'hFF, 8'hFF, 1'b1);
        idle(4);

        // SUB wrap then XOR back-to-back, then AND with stalled sink
        step(1'b0, 1'b1, 3'd5, 8'h03, 8'h05, 1'b1);
        step(1'b0, 1'b1, 3'd3, 8'hF0, 8'h3C, 1'b1);
        step(1'b0, 1'b1, 3'd2, 8'hAA, 8'h0F, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd1, 8'h11, 8'h22, 1'b0);
        idle(2);

        // Illegal opcode followed by a legal one
        step(1'b0, 1'b1, 3'd7, 8'h12, 8'h34, 1'b1);
        step(1'b0, 1'b1, 3'd1, 8'h01, 8'h01, 1'b1);
        idle(2);

        // Reset one cycle into a MUL, then a fresh ADD
        step(1'b0, 1'b1, 3'd4, 8'hFF, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1);
        idle(4);
        step(1'b0, 1'b1, 3'd1, 8'h02, 8'h03, 1'b1);
        idle(2);

        // Random traffic with random back-pressure and rare resets
        for (int i = 0; i < 600; i++) begin
            logic [2:0] ro;
            ro = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            step(($urandom_range(0, 120) == 0), ($urandom_range(0, 3) != 0), ro,
                 WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 2) != 0));
        end
        idle(MUL_LATENCY + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tinyalu_stream.md
# tinyalu_stream

Parametrised, flow-controlled successor to the fixed 8-bit TinyALU. It executes one operation at a time on WIDTH-bit unsigned operands and returns a 2·WIDTH-bit result. Single-cycle ops complete in one cycle; the multiply path has a configurable latency of MUL_LATENCY cycles. The block sits between a command source and a result sink, with valid/ready handshakes on both sides, back-pressure on the result, and an error flag for illegal opcodes.

## Interface
- WIDTH, 8: operand width in bits, ≥ 2.
- MUL_LATENCY, 3: cycles from multiply acceptance to out_valid, ≥ 1.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  command valid.
- in_ready  out  1  block can accept a command.
- op  in  3  opcode, op_e.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  sink accepts the result.
- result  out  2·WIDTH  result, stable while out_valid.
- err  out  1  qualifies the result: 1 means the opcode was illegal.

## Operation
- Opcodes:
  - NOP=000 → 0.
  - ADD=001 → a+b, zero-extended; the carry lands in bit WIDTH.
  - AND=010 and XOR=011 → zero-extended.
  - MUL=100 → full unsigned a·b.
  - SUB=101 → (a−b) mod 2^(2·WIDTH); a<b wraps, so the result is sign-extended two's complement.
  - 110 and 111 are illegal → result 0, err=1.
- A command is accepted on a cycle where in_valid && in_ready. a, b and op are captured on acceptance; later input changes are ignored.
- The FSM has three states:
  - IDLE: in_ready=1. Accepting MUL → EXEC. Accepting any other op → DONE.
  - EXEC: in_ready=0. A down-counter loads MUL_LATENCY−1 on acceptance. When the counter reaches 0 → DONE.
  - DONE: out_valid=1, and result/err are held. If out_ready=1: go to IDLE, or take a new command in the same cycle when in_valid=1 (see in_ready below). If out_ready=0: stay in DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back issue without a bubble; in_ready depends combinationally on out_ready.
- MUL_LATENCY=1: MUL bypasses EXEC and behaves like a single-cycle op.
- Only one command is outstanding at a time; the block never reorders.

## Timing
- While rst=1, and on the first cycle after rst falls: state=IDLE, out_valid=0, result=0, err=0, counter=0. in_ready=0 while rst=1 and 1 afterwards.
- Single-cycle ops: accepted at edge N, out_valid=1 from edge N+1.
- MUL: accepted at edge N, out_valid=1 from edge N+MUL_LATENCY.
- result and err change only on the edge that enters DONE. Outside DONE, result holds its last value and err=0.
- Simultaneous out handshake and new accept in DONE: the old result retires, and the new command follows the latencies above measured from that edge.
- rst asserted mid-EXEC or mid-DONE: the in-flight result is dropped and never presented. All outputs return to reset values on the next edge.
- A stalled out_ready for any number of cycles loses no data and does not change result.

## Structure
- Package tinyalu_pkg holds:
  - op_e: 3-bit enum with the encodings above, including the illegal codes.
  - state_e: IDLE, EXEC, DONE.
  - function is_legal(op_e).
- Sub-module alu_mult_pipe #(WIDTH, MUL_LATENCY):
  - Registered unsigned multiplier with enable.
  - Its product is valid exactly MUL_LATENCY cycles after the enable cycle.
  - The top FSM owns the counter and does not use a valid output from the multiplier.
- Single-cycle ops are a combinational case on the captured operands, registered on entry to DONE.

## Test plan
- Reset, then WIDTH=8, ADD a=0xFF b=0x01 → out_valid 1 cycle after accept, result=0x0100, err=0.
- MUL_LATENCY=3, MUL a=0xFF b=0xFF → in_ready=0 for 2 cycles, out_valid 3 cycles after accept, result=0xFE01.
- SUB a=0x03 b=0x05 → result=0xFFFE. Then XOR 0xF0^0x3C → 0x00CC, issued back-to-back with out_ready held 1: one result per cycle, no bubbles.
- Hold out_ready=0 for 5 cycles after AND 0xAA&0x0F: out_valid and result=0x000A stay stable, in_ready=0. Release: retires in 1 cycle.
- op=111, a=0x12, b=0x34 → out_valid after 1 cycle, result=0, err=1. The next legal op returns err=0.
- Assert rst one cycle into a MUL (MUL_LATENCY=3) → out_valid never rises for that op. All outputs are 0 and in_ready=1 after reset. A fresh ADD 2+3 returns 0x0005.
